judge_ctrl: RTL and testbench
=============================

# judge_ctrl

Rhythm-game judge and sequencer that sits between the lane/note logic and the score counter. Tracks a per-lane hit window for each arriving note and converts button presses into one-cycle hit pulses. Maintains the combo and miss tallies and sequences a song session (clear, play, drain, done). Its `hit[1:0]` and `combo` outputs drive the score counter's `Inp` and `combo` inputs directly. Its `score_clr` output drives the score counter's reset.

## Interface
- `WINDOW`, 6: hit-window length in cycles after a note arrives; legal range 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begins a session from IDLE or DONE, ignored otherwise.
- `song_end`  in  1  pulse; last note has been issued; honoured only in PLAY.
- `note_arrive`  in  2  per-lane pulse: a note reached the judge row; honoured only in PLAY.
- `btn`  in  2  per-lane button level, already synchronized/debounced.
- `hit`  out  2  registered one-cycle pulse per lane on a judged hit.
- `combo`  out  8  current combo, saturating at 255.
- `miss_cnt`  out  8  misses this session, saturating at 255.
- `score_clr`  out  1  one-cycle pulse in CLEAR.
- `playing`  out  1  high in PLAY and DRAIN.
- `done`  out  1  high in DONE.

## Operation
- FSM states:
  - IDLE -> CLEAR on `start`.
  - CLEAR -> PLAY unconditionally after 1 cycle.
  - PLAY -> DRAIN on `song_end`.
  - DRAIN -> DONE when both lane windows are closed.
  - DONE -> CLEAR on `start`.
- CLEAR behaviour: `combo`, `miss_cnt` and both window counters are zeroed, and `score_clr` is asserted.
- Per lane, window counter `win[i]` (8 bit):
  - `note_arrive[i]` in PLAY loads `WINDOW`.
  - Otherwise a non-zero counter decrements by 1 each cycle.
- Press edge: `btn[i] & ~btn_q[i]`, where `btn_q` is the previous-cycle `btn`.
- Hit: press edge while `win[i] != 0` gives `hit[i]=1` next cycle and sets `win[i]` to 0.
  - One hit per note.
  - A press with no open window is ignored (no penalty).
- Miss: either of the following counts as a miss and increments `miss_cnt` (saturating).
  - `win[i]==1` with no press edge that cycle (window expiry).
  - `note_arrive[i]` while `win[i]!=0` and no press edge that cycle. The old note is missed and the window is reloaded.
- Press edge and `note_arrive` on the same lane, same cycle, with an open window: the hit is credited to the old note and the window reloads for the new note.
- Combo update each cycle, with h = number of lanes hit (0..2) and any miss in either lane:
  - Any miss: combo becomes 0, even if the other lane hit. `hit` pulses are still emitted, so score is still added.
  - Otherwise: combo becomes min(combo+h, 255).
- `miss_cnt` adds the number of lanes missing in the cycle (0..2), saturating at 255.
- Outside PLAY/DRAIN:
  - `note_arrive` is ignored.
  - Press edges produce no hit.
  - Combo and miss tallies hold.
- DRAIN keeps judging open windows to completion; new notes are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE; `hit=0`, `combo=0`, `miss_cnt=0`, `score_clr=0`, `playing=0`, `done=0`; `win=0`.
  - `btn_q=2'b11`, so a button held through reset yields no edge.
- `note_arrive` at cycle t: window is open (press edge judgeable) at cycles t+1 .. t+WINDOW.
- Press edge sampled at cycle t: `hit` and the updated `combo` are visible at t+1, in the same cycle, so the score counter samples a consistent pair.
- Expiry judged at cycle t (`win==1`): `combo=0` and `miss_cnt` increment are visible at t+1.
- `start` at t: state is CLEAR and `score_clr=1` at t+1; state is PLAY at t+2.
- `reset` mid-session returns to IDLE next cycle, discarding open windows without counting misses.
- `song_end` and `note_arrive` in the same cycle: the note is accepted, then the FSM enters DRAIN.

## Structure
- `judge_pkg` holds:
  - the state enum (IDLE, CLEAR, PLAY, DRAIN, DONE);
  - `NUM_LANES=2`;
  - `COMBO_MAX=8'd255` and `MISS_MAX=8'd255`.
- Sub-module `lane_judge` is instantiated once per lane. It holds `win`, `btn_q` and press-edge detection, and outputs per-cycle `hit_now`/`miss_now`.
- The top level holds the FSM, the combo/miss arithmetic and the output registers.

## Test plan
- Reset, `start`: `score_clr` is high exactly 1 cycle; `playing` rises 2 cycles after `start`; `combo=0`, `miss_cnt=0`.
- Lane 0 note, press 3 cycles later, repeated 300 times: 300 `hit[0]` pulses, `combo` saturates at 255, `miss_cnt=0`.
- Note with no press (WINDOW=6): miss judged at cycle t+6; `combo=0` and `miss_cnt=1` at t+7; no `hit`.
- Combo 10, both lanes pressed in the same cycle inside windows: `hit=2'b11`, combo 12. Then lane 0 hit and lane 1 expiry in the same cycle: `hit=2'b01`, combo 0, `miss_cnt+1`.
- Second note on a lane with its window still open and no press: `miss_cnt+1`, window reloads to WINDOW, and a later press gives a hit.
- `song_end` with one window open: DRAIN until that window closes, then `done=1` and new notes are ignored. `start` then re-enters CLEAR. Button held through `reset` produces no hit.

Source files
------------

// File: rtl/judge_pkg.sv
// Shared types and constants for the rhythm-game judge: FSM states, lane count,
// tally limits and a saturating adder used by both tallies.
package judge_pkg;

  localparam int         NUM_LANES = 2;
  localparam int         WIN_W     = 8;
  localparam logic [7:0] COMBO_MAX = 8'd255;
  localparam logic [7:0] MISS_MAX  = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PLAY,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [7:0] sat_add(input logic [7:0] a,
                                         input logic [1:0] b,
                                         input logic [7:0] lim);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return (sum > {1'b0, lim}) ? lim : sum[7:0];
  endfunction

endpackage

// File: rtl/lane_judge.sv
// One lane of the judge: hit-window countdown, press-edge detection and the
// per-cycle hit/miss verdict for the note currently in the window.
module lane_judge
  import judge_pkg::*;
#(
  parameter int WINDOW = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic active_i,
  input  logic accept_i,
  input  logic note_i,
  input  logic btn_i,
  output logic hit_now_o,
  output logic miss_now_o,
  output logic open_o
);

  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(1);

  logic [WIN_W-1:0] win_q, win_d;
  logic             btn_q;
  logic             press;
  logic             load;

  assign press  = btn_i & ~btn_q;
  assign open_o = (win_q != '0);
  assign load   = accept_i & note_i;

  // A new note on an open window with no press misses the old note; the
  // expiry case is folded into the same term since a reload also ends it.
  assign hit_now_o  = active_i & press & open_o;
  assign miss_now_o = active_i & ~press & ((win_q == WIN_LAST) | (load & open_o));

  // NOTE: always_comb starts from a default so every path assigns win_d and no latch is inferred.
  always_comb begin
    win_d = win_q;
    if (clr_i)           win_d = '0;
    else if (load)       win_d = WIN_LOAD;
    else if (hit_now_o)  win_d = '0;
    else if (open_o)     win_d = win_q - WIN_LAST;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= '0;
      btn_q <= 1'b1;
    end else begin
      win_q <= win_d;
      btn_q <= btn_i;
    end
  end

endmodule

// File: rtl/judge_ctrl.sv
// Rhythm-game judge: session FSM, per-lane judging, combo/miss tallies and the
// registered outputs that feed the score counter.
module judge_ctrl
  import judge_pkg::*;
#(
  parameter int WINDOW = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 song_end,
  input  logic [NUM_LANES-1:0] note_arrive,
  input  logic [NUM_LANES-1:0] btn,
  output logic [NUM_LANES-1:0] hit,
  output logic [7:0]           combo,
  output logic [7:0]           miss_cnt,
  output logic                 score_clr,
  output logic                 playing,
  output logic                 done
);

  state_e state_q, state_d;

  logic [NUM_LANES-1:0] hit_now, miss_now, win_open;
  logic [NUM_LANES-1:0] hit_q;
  logic [7:0]           combo_q, combo_d, miss_q, miss_d;
  logic                 score_clr_q, score_clr_d;
  logic                 playing_q, playing_d;
  logic                 done_q, done_d;
  logic [1:0]           n_hit, n_miss;
  logic                 in_clear, active, accept;

  assign in_clear = (state_q == CLEAR);
  assign active   = (state_q == PLAY) || (state_q == DRAIN);
  assign accept   = (state_q == PLAY);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_judge #(.WINDOW(WINDOW)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (in_clear),
      .active_i   (active),
      .accept_i   (accept),
      .note_i     (note_arrive[i]),
      .btn_i      (btn[i]),
      .hit_now_o  (hit_now[i]),
      .miss_now_o (miss_now[i]),
      .open_o     (win_open[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = PLAY;
      PLAY:    if (song_end) state_d = DRAIN;
      DRAIN:   if (win_open == '0) state_d = DONE;
      DONE:    if (start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_comb begin
    score_clr_d = (state_d == CLEAR);
    playing_d   = (state_d == PLAY) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
  end

  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_hit  = n_hit  + {1'b0, hit_now[i]};
      n_miss = n_miss + {1'b0, miss_now[i]};
    end
  end

  // A miss on either lane breaks the combo even when the other lane hits.
  always_comb begin
    combo_d = combo_q;
    miss_d  = miss_q;
    if (in_clear) begin
      combo_d = '0;
      miss_d  = '0;
    end else begin
      combo_d = (n_miss != '0) ? '0 : sat_add(combo_q, n_hit, COMBO_MAX);
      miss_d  = sat_add(miss_q, n_miss, MISS_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q       <= '0;
      combo_q     <= '0;
      miss_q      <= '0;
      score_clr_q <= 1'b0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      hit_q       <= hit_now;
      combo_q     <= combo_d;
      miss_q      <= miss_d;
      score_clr_q <= score_clr_d;
      playing_q   <= playing_d;
      done_q      <= done_d;
    end
  end

  assign hit       = hit_q;
  assign combo     = combo_q;
  assign miss_cnt  = miss_q;
  assign score_clr = score_clr_q;
  assign playing   = playing_q;
  assign done      = done_q;

endmodule

// File: tb/tb_judge_ctrl.sv
// Directed bench for judge_ctrl: expected hit/miss events go into a scoreboard
// queue, a negedge monitor pops one whenever the DUT shows a hit or a new miss.
module tb_judge_ctrl;

  typedef struct packed {
    logic [1:0] hit;
    logic [7:0] combo;
    logic [7:0] miss;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, song_end;
  logic [1:0] note_arrive, btn;
  logic [1:0] hit;
  logic [7:0] combo, miss_cnt;
  logic       score_clr, playing, done;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [7:0] prev_miss;

  judge_ctrl #(.WINDOW(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .song_end    (song_end),
    .note_arrive (note_arrive),
    .btn         (btn),
    .hit         (hit),
    .combo       (combo),
    .miss_cnt    (miss_cnt),
    .score_clr   (score_clr),
    .playing     (playing),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic note(input logic [1:0] lanes);
    note_arrive = lanes;
    cyc(1);
    note_arrive = 2'b00;
  endtask

  task automatic press(input logic [1:0] lanes);
    btn = btn | lanes;
    cyc(1);
    btn = btn & ~lanes;
  endtask

  task automatic push(input logic [1:0] h, input logic [7:0] c, input logic [7:0] m);
    exp_t e;
    e.hit = h; e.combo = c; e.miss = m;
    sb.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("score_clr_pulse", score_clr, 1);
    check("playing_in_clear", playing, 0);
    cyc(1);
    check("score_clr_drop", score_clr, 0);
    check("playing_rise", playing, 1);
    check("combo_cleared", combo, 0);
    check("miss_cleared", miss_cnt, 0);
  endtask

  // Monitor: a hit pulse or a fresh miss increment is one scoreboard event.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (hit != 2'b00 || (miss_cnt != prev_miss && miss_cnt != 8'd0)) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got hit=%b combo=%0d miss=%0d expected none at %0t",
                   hit, combo, miss_cnt, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_hit", hit, e.hit);
          check("sb_combo", combo, e.combo);
          check("sb_miss", miss_cnt, e.miss);
        end
      end
    end
    prev_miss = miss_cnt;
  end

  initial begin
    reset = 1'b1; start = 1'b0; song_end = 1'b0; note_arrive = 2'b00; btn = 2'b00;
    cyc(3);
    reset = 1'b0;
    check("rst_hit", hit, 0);
    check("rst_combo", combo, 0);
    check("rst_miss", miss_cnt, 0);
    check("rst_score_clr", score_clr, 0);
    check("rst_playing", playing, 0);
    check("rst_done", done, 0);
    cyc(1);
    do_start();

    // 300 lane-0 hits: combo climbs and saturates at 255.
    for (int i = 0; i < 300; i++) begin
      push(2'b01, (i + 1 > 255) ? 8'd255 : 8'(i + 1), 8'd0);
      note(2'b01);
      cyc(2);
      press(2'b01);
    end
    check("combo_saturated", combo, 255);

    // Unpressed note: expiry judged on the 6th cycle, visible the cycle after.
    push(2'b00, 8'd0, 8'd1);
    note(2'b01);
    cyc(5);
    check("expiry_not_early", miss_cnt, 0);
    cyc(1);
    check("expiry_miss", miss_cnt, 1);
    check("expiry_combo", combo, 0);

    // Build combo to 10 on lane 1, then a double hit.
    for (int i = 0; i < 10; i++) begin
      push(2'b10, 8'(i + 1), 8'd1);
      note(2'b10);
      cyc(2);
      press(2'b10);
    end
    push(2'b11, 8'd12, 8'd1);
    note(2'b11);
    cyc(1);
    press(2'b11);

    // Lane 0 hit coincides with lane 1 expiry: hit still shown, combo breaks.
    push(2'b01, 8'd0, 8'd2);
    note(2'b10);
    cyc(2);
    note(2'b01);
    cyc(2);
    press(2'b01);

    // Re-note on an open window: miss, reload, hit on the reloaded last cycle.
    push(2'b00, 8'd0, 8'd3);
    push(2'b01, 8'd1, 8'd3);
    note(2'b01);
    cyc(2);
    note(2'b01);
    cyc(5);
    press(2'b01);

    // Press and note together: old note hit, window reloaded for the new one.
    push(2'b10, 8'd2, 8'd3);
    push(2'b10, 8'd3, 8'd3);
    note(2'b10);
    cyc(2);
    note_arrive = 2'b10;
    btn = 2'b10;
    cyc(1);
    note_arrive = 2'b00;
    btn = 2'b00;
    cyc(2);
    press(2'b10);

    // song_end with a note in the same cycle; drain until that window expires.
    push(2'b00, 8'd0, 8'd4);
    note_arrive = 2'b01;
    song_end = 1'b1;
    cyc(1);
    note_arrive = 2'b00;
    song_end = 1'b0;
    check("drain_playing", playing, 1);
    note(2'b10);
    press(2'b10);
    cyc(4);
    check("drain_miss", miss_cnt, 4);
    check("drain_not_done", done, 0);
    cyc(1);
    check("done_set", done, 1);
    check("done_not_playing", playing, 0);
    note(2'b01);
    cyc(2);
    press(2'b01);
    cyc(8);
    check("done_hold_miss", miss_cnt, 4);
    check("done_hold", done, 1);

    // Restart from DONE, then reset mid-session with buttons held.
    do_start();
    push(2'b11, 8'd2, 8'd0);
    note(2'b11);
    cyc(2);
    press(2'b11);
    note(2'b11);
    btn = 2'b11;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check("midrst_playing", playing, 0);
    check("midrst_combo", combo, 0);
    check("midrst_miss", miss_cnt, 0);
    check("midrst_hit", hit, 0);
    do_start();
    push(2'b00, 8'd0, 8'd2);
    note(2'b11);
    cyc(8);
    check("held_btn_miss", miss_cnt, 2);
    btn = 2'b00;
    cyc(3);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
